// File: rtl/sort_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sort_job_scheduler
// Brief    : Round-robin job scheduler in front of one shared insertion-sort engine.
// Revision : 1.0
// ============================================================================
module sort_job_scheduler #(
  parameter int NREQ   = 4,
  parameter int DW     = 32,
  parameter int CW     = 8,
  parameter int MAXCNT = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CW-1:0]       req_count,
  output logic [NREQ-1:0]          req_accept,
  output logic [NREQ-1:0]          req_err,
  output logic [NREQ-1:0]          grant,
  input  logic                     src_valid,
  input  logic [DW-1:0]            src_data,
  output logic                     src_ready,
  output logic                     srt_start,
  output logic [CW-1:0]            srt_count,
  output logic                     srt_load_valid,
  output logic [DW-1:0]            srt_load_data,
  input  logic                     srt_load_ready,
  input  logic                     srt_done,
  input  logic                     srt_out_valid,
  input  logic [DW-1:0]            srt_out_data,
  output logic                     srt_out_ready,
  output logic                     res_valid,
  output logic [DW-1:0]            res_data,
  output logic                     res_last,
  output logic [$clog2(NREQ)-1:0]  res_id,
  input  logic                     res_ready,
  output logic                     busy
);

  localparam int            c_pw        = $clog2(NREQ);
  localparam logic [CW-1:0] c_max_count = CW'(MAXCNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LOAD  = 3'd2,
    S_SORT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [c_pw-1:0]     r_rr_ptr, w_rr_nx;
  logic [c_pw-1:0]     r_owner, w_owner_nx;
  logic [CW-1:0]       r_count, w_count_nx;
  logic [CW-1:0]       r_n, w_n_nx;
  logic [NREQ-1:0]     r_req_accept, w_accept_nx;
  logic [NREQ-1:0]     r_req_err, w_err_nx;
  logic                r_start, w_start_nx;

  logic                w_found;
  logic [c_pw-1:0]     w_sel;
  logic [CW-1:0]       w_sel_count;
  logic                w_bad;
  logic                w_load_hs;
  logic                w_drain_hs;
  logic                w_last;

  // (base + off) mod NREQ without requiring NREQ to be a power of two
  function automatic logic [c_pw-1:0] f_wrap(input logic [c_pw-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return c_pw'(s);
  endfunction

  function automatic logic [NREQ-1:0] f_onehot(input logic [c_pw-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Scanning from the far end lets the nearest requester at/after rr_ptr win
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[f_wrap(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = f_wrap(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_sel_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == c_pw'(i)) w_sel_count = req_count[i*CW +: CW];
    end
  end

  assign w_bad      = (w_sel_count == '0) || (w_sel_count > c_max_count);
  assign w_load_hs  = (r_state == S_LOAD) && src_valid && srt_load_ready;
  assign w_drain_hs = (r_state == S_DRAIN) && srt_out_valid && res_ready;
  assign w_last     = (r_n == (r_count - CW'(1)));

  always_comb begin
    w_state_nx  = r_state;
    w_rr_nx     = r_rr_ptr;
    w_owner_nx  = r_owner;
    w_count_nx  = r_count;
    w_n_nx      = r_n;
    w_accept_nx = '0;
    w_err_nx    = '0;
    w_start_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          if (w_bad) begin
            w_err_nx = f_onehot(w_sel);
            w_rr_nx  = f_wrap(w_sel, 1);
          end else begin
            w_accept_nx = f_onehot(w_sel);
            w_owner_nx  = w_sel;
            w_count_nx  = w_sel_count;
            w_state_nx  = S_START;
          end
        end
      end
      // First START cycle carries the accept pulse, the second the srt_start pulse
      S_START: begin
        if (!r_start) begin
          w_start_nx = 1'b1;
        end else begin
          w_state_nx = S_LOAD;
          w_n_nx     = '0;
        end
      end
      S_LOAD: begin
        if (w_load_hs) begin
          w_n_nx = r_n + CW'(1);
          if ((r_n + CW'(1)) == r_count) w_state_nx = S_SORT;
        end
      end
      S_SORT: begin
        if (srt_done) begin
          w_state_nx = S_DRAIN;
          w_n_nx     = '0;
        end
      end
      S_DRAIN: begin
        if (w_drain_hs) begin
          if (w_last) begin
            w_rr_nx    = f_wrap(r_owner, 1);
            w_n_nx     = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_n_nx = r_n + CW'(1);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_count      <= '0;
      r_n          <= '0;
      r_req_accept <= '0;
      r_req_err    <= '0;
      r_start      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_rr_ptr     <= w_rr_nx;
      r_owner      <= w_owner_nx;
      r_count      <= w_count_nx;
      r_n          <= w_n_nx;
      r_req_accept <= w_accept_nx;
      r_req_err    <= w_err_nx;
      r_start      <= w_start_nx;
    end
  end

  // Data paths are pass-through but gated by state so everything reads 0 outside its phase
  assign req_accept     = r_req_accept;
  assign req_err        = r_req_err;
  assign srt_start      = r_start;
  assign srt_count      = r_count;
  assign grant          = (r_state == S_LOAD) ? f_onehot(r_owner) : '0;
  assign src_ready      = (r_state == S_LOAD) && srt_load_ready;
  assign srt_load_valid = (r_state == S_LOAD) && src_valid;
  assign srt_load_data  = (r_state == S_LOAD) ? src_data : '0;
  assign srt_out_ready  = (r_state == S_DRAIN) && res_ready;
  assign res_valid      = (r_state == S_DRAIN) && srt_out_valid;
  assign res_data       = (r_state == S_DRAIN) ? srt_out_data : '0;
  assign res_last       = (r_state == S_DRAIN) && w_last;
  assign res_id         = (r_state == S_DRAIN) ? r_owner : '0;
  assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sort_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_job_scheduler
// Brief    : Directed self-checking bench with requester, engine and result models.
// Revision : 1.0
// ============================================================================
module tb_sort_job_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*CW-1:0] req_count;
  logic [NREQ-1:0]   req_accept, req_err, grant;
  logic              src_valid, src_ready;
  logic [DW-1:0]     src_data;
  logic              srt_start;
  logic [CW-1:0]     srt_count;
  logic              srt_load_valid, srt_load_ready;
  logic [DW-1:0]     srt_load_data;
  logic              srt_done, eng_done, spur_done;
  logic              srt_out_valid, srt_out_ready;
  logic [DW-1:0]     srt_out_data;
  logic              res_valid, res_last, res_ready;
  logic [DW-1:0]     res_data;
  logic [1:0]        res_id;
  logic              busy;

  assign srt_done = eng_done | spur_done;

  always #5 clk = ~clk;

  sort_job_scheduler #(.NREQ(NREQ), .DW(DW), .CW(CW), .MAXCNT(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_count(req_count),
    .req_accept(req_accept), .req_err(req_err), .grant(grant),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .srt_start(srt_start), .srt_count(srt_count),
    .srt_load_valid(srt_load_valid), .srt_load_data(srt_load_data),
    .srt_load_ready(srt_load_ready), .srt_done(srt_done),
    .srt_out_valid(srt_out_valid), .srt_out_data(srt_out_data),
    .srt_out_ready(srt_out_ready),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .res_id(res_id), .res_ready(res_ready), .busy(busy)
  );

  int n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester sources, engine model and observation logs
  logic [DW-1:0]   src_mem [NREQ][8];
  int              src_len [NREQ];
  int              src_ptr, gi;
  logic [DW-1:0]   eng_mem [128];
  logic [DW-1:0]   tmp;
  int              eng_ph, eng_cnt, eng_n, eng_wait, j;
  bit              done_nx, toggle_ready, src_hold;
  int              cyc, acc_cyc, start_cyc, load_cyc;
  int              load_hs, mirror_err, res_last_cnt;
  logic [NREQ-1:0] acc_log[$], err_log[$];
  int              start_log[$];
  logic [DW-1:0]   load_log[$], res_d[$];
  int              res_i[$];
  bit              res_l[$];

  initial begin
    cyc = 0; eng_ph = 0; eng_cnt = 0; eng_n = 0; eng_wait = 0; src_ptr = 0;
    load_hs = 0; mirror_err = 0; res_last_cnt = 0; done_nx = 1'b0;
    acc_cyc = 0; start_cyc = 0; load_cyc = 0; gi = -1;
    eng_done = 1'b0; srt_load_ready = 1'b0; srt_out_valid = 1'b0; srt_out_data = '0;
    src_valid = 1'b0; src_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      done_nx = 1'b0;
      if (!reset) begin
        eng_ph = 0; eng_n = 0; src_ptr = 0;
      end else begin
        if (req_accept != '0) begin acc_log.push_back(req_accept); acc_cyc = cyc; end
        if (req_err != '0) err_log.push_back(req_err);
        if (srt_start) begin
          start_log.push_back(int'(srt_count));
          start_cyc = cyc; eng_ph = 1; eng_cnt = int'(srt_count); eng_n = 0; src_ptr = 0;
        end
        if (grant != '0 && src_ready !== srt_load_ready) mirror_err++;
        if (srt_load_valid && srt_load_ready) begin
          if (load_hs == 0) load_cyc = cyc;
          load_log.push_back(srt_load_data);
          load_hs++; src_ptr++;
          if (eng_ph == 1 && eng_n < 128) begin
            eng_mem[eng_n] = srt_load_data;
            eng_n++;
            if (eng_n == eng_cnt) begin
              for (int i = 1; i < eng_cnt; i++) begin
                tmp = eng_mem[i]; j = i - 1;
                while (j >= 0 && eng_mem[j] > tmp) begin eng_mem[j+1] = eng_mem[j]; j--; end
                eng_mem[j+1] = tmp;
              end
              eng_ph = 2; eng_wait = 3;
            end
          end
        end else if (eng_ph == 2) begin
          if (eng_wait == 0) begin done_nx = 1'b1; eng_ph = 3; eng_n = 0; end
          else eng_wait--;
        end else if (eng_ph == 3 && srt_out_valid && srt_out_ready) begin
          eng_n++;
          if (eng_n == eng_cnt) eng_ph = 0;
        end
        if (res_valid && res_ready) begin
          res_d.push_back(res_data); res_i.push_back(int'(res_id)); res_l.push_back(res_last);
          if (res_last) res_last_cnt++;
        end
      end
      @(posedge clk); #1;
      eng_done       = done_nx;
      srt_load_ready = (eng_ph == 1) && (!toggle_ready || cyc[0]);
      srt_out_valid  = (eng_ph == 3);
      srt_out_data   = (eng_ph == 3 && eng_n < 128) ? eng_mem[eng_n] : '0;
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (grant[i]) gi = i;
      if (gi >= 0 && !src_hold && src_ptr < src_len[gi] && src_ptr < 8) begin
        src_valid = 1'b1; src_data = src_mem[gi][src_ptr];
      end else begin
        src_valid = 1'b0; src_data = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    acc_log.delete(); err_log.delete(); start_log.delete(); load_log.delete();
    res_d.delete(); res_i.delete(); res_l.delete();
    load_hs = 0; mirror_err = 0; res_last_cnt = 0;
  endtask

  task automatic set_job(input int id, input int cnt, input logic [DW-1:0] d0, d1, d2, d3, d4);
    src_mem[id][0] = d0; src_mem[id][1] = d1; src_mem[id][2] = d2;
    src_mem[id][3] = d3; src_mem[id][4] = d4;
    src_len[id] = cnt;
    req_count[id*CW +: CW] = CW'(cnt);
  endtask

  task automatic wait_accepts(input int n, input string tag);
    int t;
    t = 0;
    while (acc_log.size() < n && t < 1000) begin
      req_valid = req_valid & ~req_err;
      tick(1); t++;
    end
    check_eq(tag, (acc_log.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_done(input int nlast, input string tag);
    int t;
    t = 0;
    while (!(busy == 1'b0 && res_last_cnt >= nlast) && t < 3000) begin tick(1); t++; end
    check_eq(tag, (t < 3000) ? 1 : 0, 1);
  endtask

  task automatic check_results(input string tag, input int cnt, input int id,
                               input logic [DW-1:0] e0, e1, e2, e3, e4);
    logic [DW-1:0] exp [5];
    exp = '{e0, e1, e2, e3, e4};
    check_eq({tag, "_size"}, res_d.size(), cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k < res_d.size()) begin
        check_eq($sformatf("%s_data%0d", tag, k), res_d[k], exp[k]);
        check_eq($sformatf("%s_id%0d", tag, k), res_i[k], id);
        check_eq($sformatf("%s_last%0d", tag, k), res_l[k], (k == cnt - 1) ? 1 : 0);
      end
    end
  endtask

  logic [19:0] order;
  int          t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; req_valid = '0; req_count = '0; res_ready = 1'b1;
    spur_done = 1'b0; toggle_ready = 1'b0; src_hold = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 0;
      for (int k = 0; k < 8; k++) src_mem[i][k] = '0;
    end

    // Reset state
    tick(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_accept_err", {req_accept, req_err}, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_start_count", {srt_start, srt_count}, 0);
    check_eq("rst_load", {srt_load_valid, srt_load_data, src_ready}, 0);
    check_eq("rst_res", {res_valid, res_data, res_last, res_id, srt_out_ready}, 0);
    reset = 1'b1;
    tick(2);

    // Fairness: all requesters pending with count 3
    clear_logs();
    set_job(0, 3, 30, 10, 20, 0, 0);
    set_job(1, 3, 6, 5, 4, 0, 0);
    set_job(2, 3, 200, 100, 300, 0, 0);
    set_job(3, 3, 2, 3, 1, 0, 0);
    req_valid = 4'hF;
    wait_accepts(5, "fair_accepts");
    req_valid = '0;
    wait_done(5, "fair_done");
    order = '0;
    for (int k = 0; k < 5; k++) if (k < acc_log.size()) order = {order[15:0], acc_log[k]};
    check_eq("fair_order", order, 20'h12481);
    check_eq("fair_res_count", res_d.size(), 15);
    if (res_i.size() >= 15)
      check_eq("fair_ids", {res_i[0][1:0], res_i[3][1:0], res_i[6][1:0], res_i[9][1:0], res_i[12][1:0]},
               10'b00_01_10_11_00);
    if (res_d.size() >= 3)
      check_eq("fair_job0", {res_d[0], res_d[1], res_d[2]}, {32'd10, 32'd20, 32'd30});

    // Single job on requester 2
    tick(1);
    clear_logs();
    set_job(2, 5, 9, 3, 7, 1, 5);
    req_valid = 4'b0100;
    wait_accepts(1, "single_accept_seen");
    req_valid = '0;
    wait_done(1, "single_done");
    if (acc_log.size() > 0) check_eq("single_accept", acc_log[0], 4'b0100);
    if (start_log.size() > 0) check_eq("single_srt_count", start_log[0], 5);
    check_eq("single_start_lat", start_cyc - acc_cyc, 1);
    check_eq("single_load_lat", load_cyc - start_cyc, 1);
    check_eq("single_load_hs", load_hs, 5);
    check_results("single", 5, 2, 1, 3, 5, 7, 9);

    // Illegal counts on 0 and 1, legal job on 2 (rr_ptr is now 3)
    tick(1);
    clear_logs();
    set_job(0, 0, 0, 0, 0, 0, 0);
    set_job(1, 101, 0, 0, 0, 0, 0);
    src_len[1] = 0;
    set_job(2, 2, 22, 11, 0, 0, 0);
    req_valid = 4'b0111;
    wait_accepts(1, "illegal_accept_seen");
    req_valid = '0;
    wait_done(1, "illegal_done");
    check_eq("illegal_err_count", err_log.size(), 2);
    if (err_log.size() >= 2) check_eq("illegal_err_order", {err_log[0], err_log[1]}, 8'b0001_0010);
    if (acc_log.size() > 0) check_eq("illegal_accept", acc_log[0], 4'b0100);
    check_eq("illegal_starts", start_log.size(), 1);
    check_results("illegal", 2, 2, 11, 22, 0, 0, 0);

    // Backpressure on load and result sides
    tick(1);
    clear_logs();
    toggle_ready = 1'b1;
    set_job(1, 4, 40, 10, 30, 20, 0);
    req_valid = 4'b0010;
    wait_accepts(1, "bp_accept_seen");
    req_valid = '0;
    t = 0;
    while (!res_valid && t < 500) begin tick(1); t++; end
    check_eq("bp_res_seen", (t < 500) ? 1 : 0, 1);
    res_ready = 1'b0;
    tick(3);
    res_ready = 1'b1;
    wait_done(1, "bp_done");
    toggle_ready = 1'b0;
    check_eq("bp_load_hs", load_hs, 4);
    if (load_log.size() >= 4)
      check_eq("bp_load_order", {load_log[0][7:0], load_log[1][7:0], load_log[2][7:0], load_log[3][7:0]},
               {8'd40, 8'd10, 8'd30, 8'd20});
    check_eq("bp_mirror", mirror_err, 0);
    check_results("bp", 4, 1, 10, 20, 30, 40, 0);

    // Reset during LOAD after two of four elements
    tick(1);
    clear_logs();
    set_job(3, 4, 8, 6, 7, 5, 0);
    req_valid = 4'b1000;
    wait_accepts(1, "rstmid_accept_seen");
    req_valid = '0;
    t = 0;
    while (load_hs < 2 && t < 200) begin tick(1); t++; end
    check_eq("rstmid_two_loaded", load_hs, 2);
    reset = 1'b0;
    #1;
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_grant_ready", {grant, src_ready, srt_load_valid}, 0);
    check_eq("rstmid_count_start", {srt_count, srt_start}, 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    check_eq("rstmid_no_last", res_last_cnt, 0);
    clear_logs();
    req_valid = 4'b1000;
    wait_accepts(1, "rstmid_repost_seen");
    req_valid = '0;
    wait_done(1, "rstmid_done");
    if (acc_log.size() > 0) check_eq("rstmid_accept", acc_log[0], 4'b1000);
    if (load_log.size() > 0) check_eq("rstmid_first_elem", load_log[0], 8);
    check_results("rstmid", 4, 3, 5, 6, 7, 8, 0);

    // Spurious srt_done in IDLE and in LOAD
    tick(1);
    clear_logs();
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(1);
    check_eq("spur_idle_busy", busy, 0);
    src_hold = 1'b1;
    set_job(0, 3, 3, 1, 2, 0, 0);
    req_valid = 4'b0001;
    wait_accepts(1, "spur_accept_seen");
    req_valid = '0;
    t = 0;
    while (grant == '0 && t < 50) begin tick(1); t++; end
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(1);
    check_eq("spur_load_grant", grant, 4'b0001);
    check_eq("spur_load_hs", load_hs, 0);
    src_hold = 1'b0;
    wait_done(1, "spur_done");
    check_results("spur", 3, 0, 1, 2, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_job_scheduler.md
# sort_job_scheduler

Arbitrates a single shared insertion-sort engine among NREQ requesters. Each requester posts a job (element count); the scheduler grants one job at a time round-robin, streams its elements from the shared source bus into the engine, waits for the engine's completion, and streams the sorted result to the result port tagged with the requester ID. It sits between the requester front-ends and the sort engine and is the only block that drives the engine's control inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 32, element width
- CW, 8, job count width
- MAXCNT, 100, largest legal job count (engine storage depth)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  NREQ  job pending, per requester; held until accepted
- req_count  in  NREQ*CW  element count per requester, slice i = [i*CW +: CW]
- req_accept  out  NREQ  one-cycle one-hot pulse: job i accepted
- req_err  out  NREQ  one-cycle one-hot pulse: job i rejected (count 0 or > MAXCNT)
- grant  out  NREQ  one-hot owner of src bus during LOAD; 0 otherwise
- src_valid  in  1  element valid from granted requester
- src_data  in  DW  element
- src_ready  out  1  element consumed
- srt_start  out  1  one-cycle pulse, engine begins a job
- srt_count  out  CW  latched job count, stable from start until job end
- srt_load_valid  out  1  element to engine
- srt_load_data  out  DW  element to engine
- srt_load_ready  in  1  engine accepts element
- srt_done  in  1  one-cycle pulse, sorting finished
- srt_out_valid  in  1  sorted element available
- srt_out_data  in  DW  sorted element
- srt_out_ready  out  1  sorted element consumed
- res_valid, res_data(DW), res_last(1), res_id($clog2(NREQ))  out  result stream
- res_ready  in  1  result consumer ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, LOAD, SORT, DRAIN.
- IDLE: if any req_valid, select first asserted index at or after rr_ptr (wrapping). If its count is 0 or > MAXCNT: pulse req_err[i], rr_ptr <= i+1 mod NREQ, stay IDLE. Else pulse req_accept[i], latch owner=i and count, go START.
- START: srt_start=1 for one cycle, srt_count=count; go LOAD; element counter n=0.
- LOAD: grant[owner]=1. srt_load_valid=src_valid; srt_load_data=src_data; src_ready=srt_load_ready (combinational pass-through). Each handshake n++. When n reaches count on a handshake, go SORT. No elements beyond count are consumed.
- SORT: wait for srt_done; srt_done outside SORT is ignored. On srt_done go DRAIN, n=0.
- DRAIN: res_valid=srt_out_valid; res_data=srt_out_data; srt_out_ready=res_ready; res_id=owner; res_last=(n==count-1). Each handshake n++; on last handshake rr_ptr <= owner+1 mod NREQ, go IDLE.
- Counters CW bits; count compared unsigned; n never exceeds count.
- One job in flight; requesters not granted see no accept and must hold req_valid.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, rr_ptr 0, owner 0, count 0, n 0; all outputs 0 (req_accept, req_err, grant, src_ready, srt_start, srt_count, srt_load_valid, srt_load_data, srt_out_ready, res_*, busy).
- Reset mid-job abandons the job; no res_last is produced; engine restarts only on the next srt_start.
- req_accept/req_err registered: asserted the cycle after IDLE samples req_valid. srt_start the cycle after accept. LOAD begins the cycle after srt_start.
- Minimum job latency, accept to first res_valid: 2 + count load cycles + engine sort time + 1.
- After the final DRAIN handshake, IDLE may accept a new job on the next cycle (one idle cycle minimum between jobs).
- Simultaneous req_valid on all ports: strict round-robin; no requester waits more than NREQ-1 jobs.
- srt_done in the same cycle as the final load handshake is ignored (SORT not yet entered).

## Test plan
- Single job: req_valid[2], count 5, data 9,3,7,1,5 -> accept[2] pulse, srt_start with count 5, 5 load handshakes, then res 1,3,5,7,9 with res_id=2, res_last only on 9.
- Fairness: all 4 requesters valid continuously, count 3 each -> service order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Illegal counts: req0 count 0, req1 count 101 -> req_err[0] then req_err[1], no srt_start, next legal job from req2 proceeds normally.
- Backpressure: srt_load_ready toggled every other cycle and res_ready low 3 cycles during DRAIN -> no element lost or duplicated; src_ready mirrors srt_load_ready; exactly count elements each way.
- Reset during LOAD after 2 of 4 elements -> all outputs 0 within same cycle, busy 0; after release, re-posted job runs from element 0.
- Spurious srt_done during IDLE and LOAD -> ignored; state advances only on srt_done in SORT.
